// File: rtl/seq_count_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_count_pkg : state encodings shared by the hit-sequence detector
// Rev 1.0
// ----------------------------------------------------------------------------
package seq_count_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] START = 2'b00;
  localparam logic [STATE_W-1:0] COUNT = 2'b01;
  localparam logic [STATE_W-1:0] DONE  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/seq_count_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_count_ctr : hit counter with synchronous clear, increment and hold
// Rev 1.0
// ----------------------------------------------------------------------------
module seq_count_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_count_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_count_fsm : detects TARGET hits on din_i (consecutive or sparse), Moore flag
// Rev 1.0
// ----------------------------------------------------------------------------
module seq_count_fsm
  import seq_count_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int TARGET = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               din_i,
  input  logic               clear_i,
  input  logic               mode_consec_i,
  input  logic               mode_rearm_i,
  output logic               dout_o,
  output logic [WIDTH-1:0]   count_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [WIDTH:0] C_TARGET = (WIDTH + 1)'(TARGET);
  localparam logic [WIDTH:0] C_ONE    = (WIDTH + 1)'(1);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [WIDTH-1:0]   count_q;
  logic               ctr_clr_d;
  logic               ctr_inc_d;
  logic               w_last_hit;

  // Count is always 0 in START, so one comparison serves both START and COUNT.
  assign w_last_hit = (({1'b0, count_q} + C_ONE) == C_TARGET);

  always_comb begin
    state_d   = state_q;
    ctr_clr_d = 1'b0;
    ctr_inc_d = 1'b0;
    if (clear_i) begin
      state_d   = START;
      ctr_clr_d = 1'b1;
    end else begin
      case (state_q)
        START: begin
          if (din_i) begin
            ctr_inc_d = 1'b1;
            state_d   = w_last_hit ? DONE : COUNT;
          end
        end
        COUNT: begin
          if (din_i) begin
            ctr_inc_d = 1'b1;
            if (w_last_hit) begin
              state_d = DONE;
            end
          end else if (mode_consec_i) begin
            state_d   = START;
            ctr_clr_d = 1'b1;
          end
        end
        DONE: begin
          if (mode_rearm_i) begin
            state_d   = START;
            ctr_clr_d = 1'b1;
          end
        end
        default: begin
          state_d   = START;
          ctr_clr_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  seq_count_ctr #(
    .WIDTH (WIDTH)
  ) u_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (ctr_clr_d),
    .inc_i  (ctr_inc_d),
    .cnt_o  (count_q)
  );

  assign dout_o  = (state_q == DONE);
  assign count_o = count_q;
  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_count_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_count_fsm : three detector variants driven in parallel, checked against a hit/done model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_seq_count_fsm;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_ni, din_i, clear_i, mode_consec_i, mode_rearm_i;

  logic       dout_t2, dout_t3, dout_t1;
  logic [3:0] count_t2, count_t1;
  logic [1:0] count_t3;
  logic [1:0] state_t2, state_t3, state_t1;

  int n_checks = 0;
  int n_errors = 0;

  int tgt [3] = '{2, 3, 1};
  int m_hits [3];
  bit m_done [3];

  seq_count_fsm #(.WIDTH(4), .TARGET(2)) u_t2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .din_i(din_i), .clear_i(clear_i),
    .mode_consec_i(mode_consec_i), .mode_rearm_i(mode_rearm_i),
    .dout_o(dout_t2), .count_o(count_t2), .state_o(state_t2)
  );

  seq_count_fsm #(.WIDTH(2), .TARGET(3)) u_t3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .din_i(din_i), .clear_i(clear_i),
    .mode_consec_i(mode_consec_i), .mode_rearm_i(mode_rearm_i),
    .dout_o(dout_t3), .count_o(count_t3), .state_o(state_t3)
  );

  seq_count_fsm #(.WIDTH(4), .TARGET(1)) u_t1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .din_i(din_i), .clear_i(clear_i),
    .mode_consec_i(mode_consec_i), .mode_rearm_i(mode_rearm_i),
    .dout_o(dout_t1), .count_o(count_t1), .state_o(state_t1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: number of hits since restart and whether the target was reached.
  task automatic model_step(input int i);
    if (!rst_ni || clear_i) begin
      m_hits[i] = 0;
      m_done[i] = 1'b0;
    end else if (m_done[i]) begin
      if (mode_rearm_i) begin
        m_hits[i] = 0;
        m_done[i] = 1'b0;
      end
    end else if (din_i) begin
      m_hits[i] = m_hits[i] + 1;
      if (m_hits[i] == tgt[i]) m_done[i] = 1'b1;
    end else if (mode_consec_i) begin
      m_hits[i] = 0;
    end
  endtask

  task automatic cycle(input bit d, input bit c, input bit rn, input bit mc, input bit mr);
    logic [31:0] obs_dout, obs_cnt, obs_st, exp_st;
    din_i = d; clear_i = c; rst_ni = rn; mode_consec_i = mc; mode_rearm_i = mr;
    @(posedge clk_i);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin obs_dout = 32'(dout_t2); obs_cnt = 32'(count_t2); obs_st = 32'(state_t2); end
        1: begin obs_dout = 32'(dout_t3); obs_cnt = 32'(count_t3); obs_st = 32'(state_t3); end
        default: begin obs_dout = 32'(dout_t1); obs_cnt = 32'(count_t1); obs_st = 32'(state_t1); end
      endcase
      exp_st = m_done[i] ? 32'd2 : ((m_hits[i] > 0) ? 32'd1 : 32'd0);
      check($sformatf("T%0d_dout", tgt[i]), obs_dout, 32'(m_done[i]));
      check($sformatf("T%0d_count", tgt[i]), obs_cnt, 32'(m_hits[i]));
      check($sformatf("T%0d_state", tgt[i]), obs_st, exp_st);
    end
  endtask

  initial begin
    din_i = 1'b0; clear_i = 1'b0; rst_ni = 1'b0; mode_consec_i = 1'b0; mode_rearm_i = 1'b0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Sparse hits, sticky DONE, then random Din
    cycle(1, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(1, 0, 1, 0, 0);
    check("sparse_done_t2", 32'(dout_t2), 32'd1);
    for (int k = 0; k < 20; k++) cycle(1'($urandom_range(0, 1)), 0, 1, 0, 0);
    check("sticky_t2", 32'(dout_t2), 32'd1);

    // Consecutive mode: a gap restarts
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 1, 1, 0); cycle(1, 0, 1, 1, 0); cycle(0, 0, 1, 1, 0);
    check("consec_gap_t3", 32'(count_t3), 32'd0);
    cycle(1, 0, 1, 1, 0); cycle(1, 0, 1, 1, 0);
    check("consec_pre_t3", 32'(dout_t3), 32'd0);
    cycle(1, 0, 1, 1, 0);
    check("consec_done_t3", 32'(dout_t3), 32'd1);

    // Rearm with Din held high: period-3 pulse for TARGET=2
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 9; k++) begin
      cycle(1, 0, 1, 0, 1);
      check("rearm_t2_pattern", 32'(dout_t2), (k % 3 == 1) ? 32'd1 : 32'd0);
    end

    // Reset mid-sequence, then reset with clear
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    check("post_reset_t2", 32'(count_t2), 32'd1);
    cycle(1, 1, 0, 0, 0);
    check("rst_clr_t2", 32'(state_t2), 32'd0);

    // Clear while in DONE
    cycle(1, 0, 1, 0, 0);
    check("t1_done", 32'(state_t1), 32'd2);
    cycle(1, 1, 1, 0, 0);
    check("t1_clear", 32'(count_t1), 32'd0);

    // Saturation for WIDTH=2, TARGET=3
    for (int k = 0; k < 10; k++) cycle(1, 0, 1, 0, 0);
    check("sat_t3", 32'(count_t3), 32'd3);

    // Fully randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 29) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_count_fsm.md
SEQ_COUNT_FSM -- requirements
Module: seq_count_fsm

Interface
REQ-001 Parameter WIDTH, default 4: hit-counter width in bits.
REQ-002 Parameter TARGET, default 2: number of Din hits required to reach DONE; legal range 1 .. 2**WIDTH-1.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  reset, synchronous, active-low.
REQ-005 Din  input  1  hit input; sampled each rising edge; 1 = hit.
REQ-006 Clear  input  1  synchronous restart to START, active-high.
REQ-007 Mode_consec  input  1  1 = hits must be consecutive; 0 = hits may be separated by any number of Din=0 cycles.
REQ-008 Mode_rearm  input  1  1 = DONE lasts one cycle, then auto-return to START; 0 = DONE is sticky.
REQ-009 Dout  output  1  detection flag; 1 exactly when state is DONE.
REQ-010 Count  output  WIDTH  hits accumulated since last START; registered.
REQ-011 State  output  2  current state encoding, for debug.

Function
REQ-012 The FSM SHALL have three states: START=2'b00, COUNT=2'b01, DONE=2'b10; 2'b11 is illegal and SHALL go to START with Count=0 on the next edge.
REQ-013 START: Count=0; Din=1 SHALL go to DONE if TARGET==1, else to COUNT with Count=1; Din=0 SHALL stay in START.
REQ-014 COUNT, Din=1: Count SHALL increment; if Count+1==TARGET, go to DONE with Count=TARGET, else stay in COUNT.
REQ-015 COUNT, Din=0: Mode_consec=1 SHALL go to START with Count=0; Mode_consec=0 SHALL hold state and Count.
REQ-016 DONE: Mode_rearm=0 SHALL stay in DONE with Count=TARGET regardless of Din; Mode_rearm=1 SHALL go to START with Count=0 on the next edge, and Din in that cycle SHALL be ignored.
REQ-017 Dout SHALL be a Moore output decoded only from the state register (no combinational path from Din).
REQ-018 Latency: the edge that samples the TARGET-th hit SHALL move the FSM to DONE; Dout SHALL be 1 in the cycle after that edge.
REQ-019 Count SHALL never exceed TARGET and SHALL never wrap.
REQ-020 Mode inputs SHALL be sampled every cycle; a mode change mid-sequence SHALL apply from the next edge without clearing Count.
REQ-021 Clear=1 SHALL force START with Count=0 on the next edge, overriding Din and all modes.
REQ-022 With defaults (TARGET=2) and Mode_consec=0, Mode_rearm=0, the behaviour SHALL be: two hits, not necessarily adjacent, then sticky Dout=1.

Reset
REQ-023 Reset_n=0 at a rising edge SHALL set State=START, Count=0 and Dout=0; Reset_n has priority over Clear.
REQ-024 Reset asserted mid-sequence or while in DONE SHALL discard all progress; the first hit after release SHALL count as hit 1.
REQ-025 The block SHALL have no asynchronous reset path; Reset_n held low SHALL keep the block in reset.

Structure
REQ-026 Package seq_count_pkg SHALL hold the state encodings (START, COUNT, DONE) and the state width constant.
REQ-027 The hit counter (synchronous clear, increment, hold) SHALL be a sub-module seq_count_ctr, parametrised by WIDTH.
REQ-028 The FSM SHALL use one sequential process for the state and Count registers and one combinational process for next-state logic, with a default assignment for every signal.

Verification
REQ-029 Defaults, Din=1,0,0,1 after reset -> Dout=0 for 4 cycles, then Dout=1; Dout stays 1 for 20 further cycles with random Din.
REQ-030 TARGET=3, Mode_consec=1, Din=1,1,0,1,1,1 -> Count=1,2,0,1,2,3; Dout=1 only after the 6th edge.
REQ-031 TARGET=2, Mode_rearm=1, Din held at 1 -> Dout pattern 0,0,1,0,0,1,... with period 3.
REQ-032 Reset_n=0 for one edge while in COUNT with Count=1, then Din=1 -> Count=1 and Dout=0; Reset_n=0 together with Clear=1 -> START.
REQ-033 TARGET=1, Din=1 in START -> DONE after one edge; Clear=1 in DONE -> START with Count=0 on the next edge.
REQ-034 WIDTH=2, TARGET=3, 10 hits with Mode_rearm=0 -> Count saturates at 3 and never wraps.
